// File: rtl/trivium_stream.sv
// trivium_stream -- Trivium stream cipher (80-bit key, 80-bit IV) that XORs
// a W-bit-per-cycle keystream onto a valid/ready data stream.
//
// Parameters
//   W      keystream bits per step (1, 2, 4, 8, 16, 32 or 64)
//   LEN_W  width of the word-count port Len
//
// Ports
//   CLK, RSTn        clock (rising edge), asynchronous active-low reset
//   EN               global enable; low freezes all state and outputs
//   Kin, Krdy        80-bit key and key-load strobe (accepted while idle)
//   IVin, IVrdy      80-bit IV and IV-load/start strobe (accepted while idle)
//   Len              number of W-bit words in the message, sampled on IV load
//   Din, Din_vld,    input data word handshake
//   Din_rdy
//   Dout, Dout_vld,  output word (Din XOR keystream) handshake
//   Dout_rdy
//   Kvld             one-cycle pulse after a key load
//   BSY              high from IV load until the message ends
//   Done             one-cycle pulse when the last word leaves
//   Abort            only with TRIVIUM_STREAM_ABORT_EN defined: drops the
//                    current message and returns to idle, keeping the key
//
// Bit order: Kin/IVin are byte-reversed on load (Kin[79:72] is key byte 0),
// key byte i bit j is Trivium key bit K(8i+j+1), and Dout[j] carries the
// j-th keystream bit of the step (Dout[0] is the earliest).
module trivium_stream #(
  parameter int W     = 8,
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
`ifdef TRIVIUM_STREAM_ABORT_EN
  input  logic             Abort,
`endif
  input  logic [79:0]      Kin,
  input  logic             Krdy,
  input  logic [79:0]      IVin,
  input  logic             IVrdy,
  input  logic [LEN_W-1:0] Len,
  input  logic [W-1:0]     Din,
  input  logic             Din_vld,
  output logic             Din_rdy,
  output logic [W-1:0]     Dout,
  output logic             Dout_vld,
  input  logic             Dout_rdy,
  output logic             Kvld,
  output logic             BSY,
  output logic             Done
);

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
      $error("trivium_stream: W must be one of 1, 2, 4, 8, 16, 32, 64");
    end
  endgenerate

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_INIT    = 2'd1;
  localparam logic [1:0]  S_STREAM  = 2'd2;
  localparam logic [10:0] INIT_LAST = 11'(1152 / W - 1);

  logic [1:0]       fsm_q, fsm_d;
  logic [79:0]      key_q, key_d;
  logic [287:0]     st_q, st_d;
  logic [10:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             kvld_q, kvld_d;
  logic             done_q, done_d;
  logic             bsy_q, bsy_d;

  logic             abort_req;
  logic             din_rdy;
  logic             accept;
  logic             xfer;
  logic [287:0]     st_adv;
  logic [W-1:0]     ks;
  logic [287:0]     rs;
  logic             t1, t2, t3;

`ifdef TRIVIUM_STREAM_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [79:0] byte_rev(input logic [79:0] x);
    logic [79:0] r;
    r = '0;
    for (int unsigned b = 0; b < 10; b++) begin
      r[8*b +: 8] = x[8*(9-b) +: 8];
    end
    return r;
  endfunction

  // W unrolled Trivium rounds. State bit s(n) of the Trivium paper lives in
  // st[n-1]; ks[i] is the keystream bit of round i.
  always_comb begin
    rs = st_q;
    ks = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      t1    = rs[65]  ^ rs[92];
      t2    = rs[161] ^ rs[176];
      t3    = rs[242] ^ rs[287];
      ks[i] = t1 ^ t2 ^ t3;
      t1    = t1 ^ (rs[90]  & rs[91])  ^ rs[170];
      t2    = t2 ^ (rs[174] & rs[175]) ^ rs[263];
      t3    = t3 ^ (rs[285] & rs[286]) ^ rs[68];
      rs    = {rs[286:177], t2, rs[175:93], t1, rs[91:0], t3};
    end
    st_adv = rs;
  end

  // Din_rdy follows the handshake formula as-is; EN is a system-wide stall,
  // so upstream is expected to hold off while EN is low.
  assign din_rdy = (fsm_q == S_STREAM) & (!dout_vld_q | Dout_rdy) & (acc_q < len_q);
  assign accept  = Din_vld & din_rdy;
  assign xfer    = dout_vld_q & Dout_rdy;

  always_comb begin
    fsm_d      = fsm_q;
    key_d      = key_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    kvld_d     = kvld_q;
    done_d     = done_q;
    bsy_d      = bsy_q;

    if (EN) begin
      kvld_d = 1'b0;
      done_d = 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (Krdy) begin
            key_d  = byte_rev(Kin);
            kvld_d = 1'b1;
          end else if (IVrdy) begin
            st_d  = {3'b111, 108'b0, 4'b0, byte_rev(IVin), 13'b0, key_q};
            len_d = Len;
            acc_d = '0;
            cnt_d = '0;
            bsy_d = 1'b1;
            fsm_d = S_INIT;
          end
        end

        S_INIT: begin
          if (abort_req) begin
            fsm_d      = S_IDLE;
            bsy_d      = 1'b0;
            dout_vld_d = 1'b0;
          end else begin
            st_d = st_adv;
            if (cnt_q == INIT_LAST) begin
              cnt_d = '0;
              if (len_q == '0) begin
                fsm_d  = S_IDLE;
                bsy_d  = 1'b0;
                done_d = 1'b1;
              end else begin
                fsm_d = S_STREAM;
              end
            end else begin
              cnt_d = cnt_q + 11'd1;
            end
          end
        end

        S_STREAM: begin
          if (abort_req) begin
            fsm_d      = S_IDLE;
            bsy_d      = 1'b0;
            dout_vld_d = 1'b0;
          end else begin
            if (accept) begin
              st_d       = st_adv;
              dout_d     = Din ^ ks;
              dout_vld_d = 1'b1;
              acc_d      = acc_q + 1'b1;
            end else if (xfer) begin
              dout_vld_d = 1'b0;
            end
            // Once every word has been accepted, the word in the output
            // register is the last one; its transfer ends the message.
            if (xfer && (acc_q == len_q)) begin
              fsm_d      = S_IDLE;
              bsy_d      = 1'b0;
              done_d     = 1'b1;
              dout_vld_d = 1'b0;
            end
          end
        end

        default: begin
          fsm_d = S_IDLE;
          bsy_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fsm_q      <= S_IDLE;
      key_q      <= '0;
      st_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      kvld_q     <= 1'b0;
      done_q     <= 1'b0;
      bsy_q      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      key_q      <= key_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      kvld_q     <= kvld_d;
      done_q     <= done_d;
      bsy_q      <= bsy_d;
    end
  end

  assign Din_rdy  = din_rdy;
  assign Dout     = dout_q;
  assign Dout_vld = dout_vld_q;
  assign Kvld     = kvld_q;
  assign BSY      = bsy_q;
  assign Done     = done_q;

endmodule
